cond_unit: RTL
==============

# cond_unit

Conditional-execution stage of the multicycle ARM controller, directly downstream of the instruction decoder. It holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against it. It gates the decoder's raw write requests (PCS, NextPC, RegW, MemW, FlagW) into the committed write enables that drive the datapath. The condition result is registered one cycle so that gating in later FSM states uses the value computed when the instruction was decoded.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- Cond  input  4  condition field, Instr[31:28]
- ALUFlags  input  4  {N,Z,C,V} from the ALU this cycle
- FlagW  input  2  decoder flag-write request; [1] = NZ group, [0] = CV group
- PCS  input  1  decoder: instruction writes PC (branch or Rd=R15 write)
- NextPC  input  1  FSM: unconditional PC+4 update (fetch)
- RegW  input  1  FSM/decoder register-write request
- MemW  input  1  FSM/decoder memory-write request
- PCWrite  output  1  committed PC write enable
- RegWrite  output  1  committed register-file write enable
- MemWrite  output  1  committed memory write enable
- Flags  output  4  current registered {N,Z,C,V}, for debug and verification
- CondExDelayed  output  1  registered condition result

## Operation
- Flag register: two independently enabled groups.
  - Flags[3:2] (N,Z) load ALUFlags[3:2] when FlagWrite[1]=1.
  - Flags[1:0] (C,V) load ALUFlags[1:0] when FlagWrite[0]=1.
- FlagWrite = FlagW & {2{CondEx}}, where CondEx is combinational from the current Flags, not the delayed value.
- CondEx decode, with N,Z,C,V taken from the Flags register:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (unsupported encoding; the instruction is squashed). Never X.
- CondExDelayed: register that loads CondEx on every rising edge, with no enable.
- Committed outputs, all combinational:
  - RegWrite = RegW & CondExDelayed
  - MemWrite = MemW & CondExDelayed
  - PCWrite = NextPC | (PCS & CondExDelayed)
- NextPC is never gated by the condition, so fetch always advances.
- Flags only change through FlagWrite. ALUFlags from address or PC+4 computations are ignored whenever FlagW=00.

## Timing
- Reset (asynchronous, immediate on assertion of reset):
  - Flags = 0000, CondExDelayed = 0.
  - Therefore RegWrite = 0, MemWrite = 0, PCWrite = NextPC.
- Release of reset is sampled at the next rising edge. State holds reset values until that edge.
- CondEx → CondExDelayed: 1-cycle latency. Gating in the cycle after decode uses the decode-cycle condition, even if Flags change in that same edge.
- Flag update: visible on Flags the cycle after the FlagW/CondEx cycle.
- Simultaneous FlagW and a Cond that depends on the old flags: CondEx uses the pre-update Flags. The new flags do not affect the current instruction.
- FlagW=10: only N,Z update; C,V hold. FlagW=01: only C,V update.
- Reset asserted mid-instruction: any pending RegWrite/MemWrite/PCS-gated write is squashed immediately, because CondExDelayed drops to 0.
- No X propagation: every output is a defined function of the registers and inputs for all 16 Cond values.

## Test plan
- Reset: assert reset with RegW=MemW=1, NextPC=0 → Flags=0000, CondExDelayed=0, RegWrite=MemWrite=PCWrite=0. Then set NextPC=1 → PCWrite=1 with no clock edge.
- Flag load and group independence: Cond=1110, FlagW=11, ALUFlags=0110, one edge → Flags=0110. Next, FlagW=10, ALUFlags=1000 → Flags=1010 (C,V held).
- Condition sweep: for each Flags value 0000..1111 and each Cond 0000..1111, check CondEx against the table. Check CondExDelayed equals it after one edge. Cond=1111 always gives 0.
- Squash: Flags=0000, Cond=0000 (EQ), RegW=MemW=PCS=1, FlagW=11, ALUFlags=0100 → after edge CondExDelayed=0, RegWrite=MemWrite=0, PCWrite=NextPC, Flags unchanged at 0000.
- Delay semantics: Flags Z=1, Cond=EQ in cycle n. In the same cycle a flag write clears Z. In cycle n+1 → CondExDelayed=1 and RegWrite=RegW, even though CondEx has become 0.
- Async reset mid-operation: CondExDelayed=1, RegW=1, assert reset between clock edges → RegWrite falls to 0 within that cycle and Flags=0000.

Source files
------------

// File: rtl/cond_unit_if.sv
// Decoder/FSM to conditional-execution stage bundle: raw write requests in,
// committed write enables and debug flag state out.
interface cond_unit_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondExDelayed;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    input  PCWrite, RegWrite, MemWrite, Flags, CondExDelayed
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    output PCWrite, RegWrite, MemWrite, Flags, CondExDelayed
  );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV flag register, condition evaluation and
// gating of the decoder's write requests with the registered condition result.
module cond_unit (
  input logic      clk,
  input logic      reset,
  cond_unit_if.slave bus
);
  logic [3:0] flags_q;
  logic       cond_ex_q;
  logic       cond_ex;
  logic [1:0] flag_write;
  logic       n, z, c, v;

  assign n = flags_q[3];
  assign z = flags_q[2];
  assign c = flags_q[1];
  assign v = flags_q[0];

  // Condition is always evaluated against the pre-update flags.
  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign flag_write = bus.FlagW & {2{cond_ex}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      if (flag_write[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
      if (flag_write[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
      cond_ex_q <= cond_ex;
    end
  end

  // Fetch advance (NextPC) is never squashed by the condition.
  assign bus.RegWrite      = bus.RegW & cond_ex_q;
  assign bus.MemWrite      = bus.MemW & cond_ex_q;
  assign bus.PCWrite       = bus.NextPC | (bus.PCS & cond_ex_q);
  assign bus.Flags         = flags_q;
  assign bus.CondExDelayed = cond_ex_q;
endmodule
